// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and decode-stall unit with a long-latency scoreboard.
// Optional stall statistics are enabled with `define FWD_STALL_STATS_EN.
module fwd_hazard_unit #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int AW         = 5,
    parameter int MAX_OUT    = 4,
    localparam int SELW      = $clog2(NUM_STAGES + 1),
    localparam int CW        = $clog2(MAX_OUT + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_SRC*AW-1:0]      rs_i,
    input  logic [NUM_SRC-1:0]         rs_used_i,
    input  logic                       issue_valid_i,
    input  logic                       issue_reg_write_i,
    input  logic [AW-1:0]              issue_rd_i,
    input  logic                       issue_long_i,
    input  logic [NUM_STAGES-1:0]      stage_reg_write_i,
    input  logic [NUM_STAGES*AW-1:0]   stage_rd_i,
    input  logic [NUM_STAGES-1:0]      stage_ready_i,
    input  logic                       long_done_i,
    input  logic [AW-1:0]              long_rd_i,
    input  logic                       flush_i,
    output logic [NUM_SRC*SELW-1:0]    fwd_sel_o,
    output logic                       stall_o,
`ifdef FWD_STALL_STATS_EN
    output logic [31:0]                stall_cnt_o,
    output logic [2:0]                 stall_cause_o,
`endif
    output logic [CW-1:0]              outstanding_o
);

    localparam int NREG = 2 ** AW;

    logic [NREG-1:0]           pending_q, pending_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic                      lu_haz, raw_haz, waw_haz, full_haz;
    logic                      stall_raw;
    logic                      accept, long_acc, done_ok;

    // Per-source bypass search: youngest matching stage wins, and a
    // not-ready winner blocks any fall-through to older stages.
    always_comb begin
        logic [AW-1:0]   rs_v;
        logic [SELW-1:0] sel_v;
        logic            found_v;
        fwd_sel = '0;
        lu_haz  = 1'b0;
        raw_haz = 1'b0;
        for (int p = 0; p < NUM_SRC; p++) begin
            rs_v    = rs_i[p*AW +: AW];
            sel_v   = '0;
            found_v = 1'b0;
            if (rs_used_i[p] && rs_v != '0) begin
                for (int s = 0; s < NUM_STAGES; s++) begin
                    if (!found_v && stage_reg_write_i[s] &&
                        stage_rd_i[s*AW +: AW] != '0 &&
                        stage_rd_i[s*AW +: AW] == rs_v) begin
                        found_v = 1'b1;
                        sel_v   = SELW'(s + 1);
                        if (!stage_ready_i[s]) lu_haz = 1'b1;
                    end
                end
                if (pending_q[rs_v]) raw_haz = 1'b1;
            end
            fwd_sel[p*SELW +: SELW] = sel_v;
        end
    end

    assign waw_haz   = issue_reg_write_i && (issue_rd_i != '0) && pending_q[issue_rd_i];
    assign full_haz  = issue_long_i && (cnt_q == CW'(MAX_OUT));
    assign stall_raw = issue_valid_i && (lu_haz || raw_haz || waw_haz || full_haz);

    assign stall_o       = rst_i ? 1'b0 : stall_raw;
    assign fwd_sel_o     = rst_i ? '0 : fwd_sel;
    assign outstanding_o = cnt_q;

    assign accept   = issue_valid_i && !stall_raw && !flush_i;
    assign long_acc = accept && issue_long_i;
    // A completion with nothing outstanding is spurious and dropped whole.
    assign done_ok  = long_done_i && (cnt_q != '0);

    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        if (flush_i) begin
            pending_d = '0;
            cnt_d     = '0;
        end else begin
            if (done_ok) pending_d[long_rd_i] = 1'b0;
            if (long_acc && issue_reg_write_i && issue_rd_i != '0)
                pending_d[issue_rd_i] = 1'b1;
            case ({long_acc, done_ok})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef FWD_STALL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [2:0]  stall_cause_q, stall_cause_d;

    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        stall_cause_d = stall_cause_q;
        if (stall_o) begin
            if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
            stall_cause_d = {full_haz, waw_haz, lu_haz | raw_haz};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q   <= '0;
            stall_cause_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            stall_cause_q <= stall_cause_d;
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign stall_cause_o = stall_cause_q;
`endif

endmodule
